// File: rtl/binary_gray_pkg.sv
// Shared constants for the binary/Gray converter slice.
// Optional feature macro used elsewhere in the slice: GRAY_STEP_CHECK_EN.
package binary_gray_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } mode_e;

endpackage

// File: rtl/binary_gray_if.sv
// Data/qualifier bundle between a code producer and the converter.
// step_err exists only when GRAY_STEP_CHECK_EN is defined.
interface binary_gray_if #(
  parameter int WIDTH = binary_gray_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] gray_comb;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
`ifdef GRAY_STEP_CHECK_EN
  logic             step_err;
`endif

  modport master (
    output in_valid, mode, din,
    input  gray_comb, out_valid, dout
`ifdef GRAY_STEP_CHECK_EN
    , input step_err
`endif
  );

  modport slave (
    input  in_valid, mode, din,
    output gray_comb, out_valid, dout
`ifdef GRAY_STEP_CHECK_EN
    , output step_err
`endif
  );
endinterface

// File: rtl/binary_gray_core.sv
// Purely combinational binary->Gray and Gray->binary of one input word.
module binary_gray_core #(
  parameter int WIDTH = binary_gray_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] b2g,
  output logic [WIDTH-1:0] g2b
);

  assign b2g = din ^ (din >> 1);

  // Each binary bit is the XOR of all Gray bits from the MSB down to it;
  // written per bit so there is no feedback through a shared vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
    assign g2b[i] = ^(din >> i);
  end

endmodule

// File: rtl/binary_gray_converter.sv
// Registered bidirectional binary/Gray converter with a zero-latency
// binary->Gray tap. Define GRAY_STEP_CHECK_EN to add step_err, which flags
// consecutive mode-0 results that differ in more than one bit.
module binary_gray_converter
  import binary_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  binary_gray_if.slave bus
);

  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] conv;
  mode_e            mode_sel;

  binary_gray_core #(.WIDTH(WIDTH)) u_core (
    .din (bus.din),
    .b2g (b2g),
    .g2b (g2b)
  );

  assign bus.gray_comb = b2g;
  assign mode_sel      = mode_e'(bus.mode);

  // Select the conversion direction for the sample being registered.
  always_comb begin
    conv = b2g;
    if (mode_sel == MODE_G2B) conv = g2b;
  end

  // Result register; dout only loads on valid so X on an idle din stays out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.dout <= conv;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             prev_vld;
  logic [WIDTH-1:0] step_diff;
  logic             multi_bit;

  assign step_diff = prev_gray ^ b2g;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi_bit = |(step_diff & (step_diff - 1'b1));

  // Remember the last mode-0 result; any gap or mode-1 sample breaks the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray    <= '0;
      prev_vld     <= 1'b0;
      bus.step_err <= 1'b0;
    end else begin
      bus.step_err <= 1'b0;
      if (bus.in_valid && mode_sel == MODE_B2G) begin
        bus.step_err <= prev_vld && multi_bit;
        prev_gray    <= b2g;
        prev_vld     <= 1'b1;
      end else begin
        prev_vld <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_binary_gray_converter.sv
// Directed bench for binary_gray_converter (WIDTH = 3).
module tb_binary_gray_converter;

  localparam int W = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  binary_gray_if #(.WIDTH(W)) bus_if ();

  binary_gray_converter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge, then settle just after the next rise.
  task automatic apply(input logic v, input logic m, input logic [W-1:0] d);
    @(negedge clk);
    bus_if.in_valid = v;
    bus_if.mode     = m;
    bus_if.din      = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] gray_tbl [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    gray_tbl[0] = 3'b000; gray_tbl[1] = 3'b001; gray_tbl[2] = 3'b011; gray_tbl[3] = 3'b010;
    gray_tbl[4] = 3'b110; gray_tbl[5] = 3'b111; gray_tbl[6] = 3'b101; gray_tbl[7] = 3'b100;

    rst_n           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.mode     = 1'b0;
    bus_if.din      = '0;
    #2;
    check("reset_dout", 32'(bus_if.dout), 32'd0);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("reset_step_err", 32'(bus_if.step_err), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Binary -> Gray over the full range, back to back.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, W'(i));
      check($sformatf("b2g_dout_%0d", i), 32'(bus_if.dout), 32'(gray_tbl[i]));
      check($sformatf("b2g_valid_%0d", i), 32'(bus_if.out_valid), 32'd1);
    end

    // Idle sweep: tap follows din immediately, registered result holds.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.din      = W'(i);
      #1;
      check($sformatf("tap_%0d", i), 32'(bus_if.gray_comb), 32'(gray_tbl[i]));
      @(posedge clk);
      #1;
      check($sformatf("idle_valid_%0d", i), 32'(bus_if.out_valid), 32'd0);
      check($sformatf("idle_hold_%0d", i), 32'(bus_if.dout), 32'b100);
    end
    apply(1'b0, 1'b0, 'x);
    check("x_idle_hold", 32'(bus_if.dout), 32'b100);

    // Gray -> binary.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b1, gray_tbl[i]);
      check($sformatf("g2b_dout_%0d", i), 32'(bus_if.dout), 32'(i));
      check($sformatf("g2b_valid_%0d", i), 32'(bus_if.out_valid), 32'd1);
    end

    // Asynchronous reset between edges while a result is held.
    apply(1'b1, 1'b0, 3'b100);
    check("pre_rst_dout", 32'(bus_if.dout), 32'b110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus_if.dout), 32'd0);
    check("async_rst_valid", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 3'b101);
    check("post_rst_dout", 32'(bus_if.dout), 32'b111);
    check("post_rst_valid", 32'(bus_if.out_valid), 32'd1);

    // Back-to-back mode switch on the same word.
    apply(1'b1, 1'b0, 3'b011);
    check("switch_b2g", 32'(bus_if.dout), 32'b010);
    check("switch_b2g_valid", 32'(bus_if.out_valid), 32'd1);
    apply(1'b1, 1'b1, 3'b011);
    check("switch_g2b", 32'(bus_if.dout), 32'b010);
    check("switch_g2b_valid", 32'(bus_if.out_valid), 32'd1);

    // Step checker scenarios (dout checked in every build).
    apply(1'b1, 1'b0, 3'b001);
    check("step_a_first", 32'(bus_if.dout), 32'b001);
`ifdef GRAY_STEP_CHECK_EN
    check("step_a_first_err", 32'(bus_if.step_err), 32'd0);
`endif
    apply(1'b1, 1'b0, 3'b011);
    check("step_a_second", 32'(bus_if.dout), 32'b010);
`ifdef GRAY_STEP_CHECK_EN
    check("step_a_err", 32'(bus_if.step_err), 32'd1);
`endif
    apply(1'b0, 1'b0, 3'b000);
`ifdef GRAY_STEP_CHECK_EN
    check("step_a_one_cycle", 32'(bus_if.step_err), 32'd0);
`endif
    apply(1'b1, 1'b0, 3'b001);
    check("step_b_first", 32'(bus_if.dout), 32'b001);
`ifdef GRAY_STEP_CHECK_EN
    check("step_b_first_err", 32'(bus_if.step_err), 32'd0);
`endif
    apply(1'b1, 1'b0, 3'b010);
    check("step_b_second", 32'(bus_if.dout), 32'b011);
`ifdef GRAY_STEP_CHECK_EN
    check("step_b_err", 32'(bus_if.step_err), 32'd0);
`endif

    apply(1'b0, 1'b0, 3'b000);
    check("final_idle_valid", 32'(bus_if.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
